// File: rtl/spi_xfer_arbiter.sv
// APB master that initialises the SPI controller and shares its APB port between NREQ byte requesters.
// Optional build macro SPI_IRQ_WAIT_EN: wait for the SPI interrupt instead of polling SR.
module spi_xfer_arbiter #(
    parameter int          NREQ     = 2,
    parameter logic [7:0]  CR1_INIT = 8'h52,
    parameter logic [7:0]  CR2_INIT = 8'h00,
    parameter logic [7:0]  BR_INIT  = 8'h11,
    parameter int          POLL_MAX = 1023
) (
    input  logic              PCLK,
    input  logic              PRESET_n,
    input  logic [NREQ-1:0]   req_i,
    input  logic [8*NREQ-1:0] req_data_i,
    output logic [NREQ-1:0]   gnt_o,
    output logic [NREQ-1:0]   done_o,
    output logic              err_o,
    output logic [7:0]        rx_data_o,
    output logic              init_done_o,
    output logic              PSEL_o,
    output logic              PENABLE_o,
    output logic              PWRITE_o,
    output logic [2:0]        PADDR_o,
    output logic [7:0]        PWDATA_o,
    input  logic [7:0]        PRDATA_i,
    input  logic              PREADY_i,
    input  logic              PSLVERR_i,
    input  logic              spi_interrupt_request_i
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(POLL_MAX + 1);

    typedef enum logic [3:0] {
        ST_INIT_CR1 = 4'd0, ST_INIT_CR2 = 4'd1, ST_INIT_BR = 4'd2, ST_IDLE = 4'd3,
        ST_WR_DR = 4'd4, ST_POLL = 4'd5, ST_WAIT_IRQ = 4'd6, ST_RD_DR = 4'd7, ST_DONE = 4'd8
    } state_t;
    // GAP is the mandatory idle cycle that precedes every SETUP.
    typedef enum logic [1:0] {PH_GAP = 2'd0, PH_SETUP = 2'd1, PH_ACCESS = 2'd2} phase_t;

    state_t            state_r, nxt_state;
    phase_t            phase_r, nxt_phase;
    logic [NREQ-1:0]   gnt_r, nxt_gnt, done_r, nxt_done;
    logic [PW-1:0]     owner_r, nxt_owner, ptr_r, nxt_ptr;
    logic [7:0]        tx_r, nxt_tx, rx_r, nxt_rx, pwdata_r, nxt_pwdata;
    logic [CW-1:0]     cnt_r, nxt_cnt, cnt_inc_s;
    logic              err_r, nxt_err, init_done_r, nxt_init_done;
    logic              psel_r, nxt_psel, penable_r, nxt_penable, pwrite_r, nxt_pwrite;
    logic [2:0]        paddr_r, nxt_paddr;
    logic [PW:0]       pick_s;
    logic              acc_done_s, fin_s, fin_err_s, is_acc_s;
    logic [7:0]        fin_rx_s;

    // Round-robin: lowest index at or after ptr with an active request; MSB flags a hit.
    function automatic logic [PW:0] rr_pick(input logic [NREQ-1:0] req, input logic [PW-1:0] ptr);
        logic [PW:0]   res;
        logic [PW-1:0] idx;
        res = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = PW'((int'(ptr) + i) % NREQ);
            if (req[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    function automatic logic [7:0] byte_sel(input logic [8*NREQ-1:0] data, input logic [PW-1:0] idx);
        logic [7:0] b;
        b = 8'h00;
        for (int k = 0; k < NREQ; k++) begin
            if (PW'(k) == idx) b = data[k*8 +: 8];
        end
        return b;
    endfunction

`ifndef SPI_IRQ_WAIT_EN
    logic unused_irq_s;
    assign unused_irq_s = spi_interrupt_request_i;
`endif

    // Next-state, datapath and registered-output computation.
    always_comb begin
        nxt_state = state_r;  nxt_phase = phase_r;  nxt_gnt = gnt_r;  nxt_owner = owner_r;
        nxt_ptr = ptr_r;  nxt_tx = tx_r;  nxt_cnt = cnt_r;  nxt_done = '0;  nxt_err = 1'b0;
        nxt_rx = rx_r;  nxt_init_done = init_done_r;
        pick_s = rr_pick(req_i, ptr_r);
        acc_done_s = (phase_r == PH_ACCESS) && PREADY_i;
        cnt_inc_s = cnt_r + CW'(1);
        fin_s = 1'b0;  fin_err_s = 1'b0;  fin_rx_s = 8'h00;
        case (phase_r)
            PH_GAP:    nxt_phase = PH_SETUP;
            PH_SETUP:  nxt_phase = PH_ACCESS;
            PH_ACCESS: nxt_phase = acc_done_s ? PH_GAP : PH_ACCESS;
            default:   nxt_phase = PH_GAP;
        endcase
        case (state_r)
            ST_INIT_CR1: nxt_state = acc_done_s ? ST_INIT_CR2 : ST_INIT_CR1;
            ST_INIT_CR2: nxt_state = acc_done_s ? ST_INIT_BR : ST_INIT_CR2;
            ST_INIT_BR: begin
                if (acc_done_s) begin
                    nxt_state = ST_IDLE;
                    nxt_init_done = 1'b1;
                end else begin
                    nxt_state = ST_INIT_BR;
                end
            end
            ST_IDLE: begin
                nxt_phase = PH_GAP;
                if (pick_s[PW]) begin
                    nxt_state = ST_WR_DR;
                    nxt_phase = PH_SETUP;
                    nxt_owner = pick_s[PW-1:0];
                    for (int k = 0; k < NREQ; k++) nxt_gnt[k] = (PW'(k) == pick_s[PW-1:0]);
                    nxt_tx = byte_sel(req_data_i, pick_s[PW-1:0]);
                    nxt_cnt = '0;
                end else begin
                    nxt_state = ST_IDLE;
                end
            end
            ST_WR_DR: begin
                if (acc_done_s && PSLVERR_i) begin
                    fin_s = 1'b1;  fin_err_s = 1'b1;
                end else if (acc_done_s) begin
`ifdef SPI_IRQ_WAIT_EN
                    nxt_state = ST_WAIT_IRQ;
`else
                    nxt_state = ST_POLL;
`endif
                end else begin
                    nxt_state = ST_WR_DR;
                end
            end
            ST_POLL: begin
                if (acc_done_s && PSLVERR_i) begin
                    fin_s = 1'b1;  fin_err_s = 1'b1;
`ifdef SPI_IRQ_WAIT_EN
                end else if (acc_done_s) begin
                    nxt_state = ST_RD_DR;
`else
                end else if (acc_done_s) begin
                    nxt_cnt = cnt_inc_s;
                    if (PRDATA_i[7]) begin
                        nxt_state = ST_RD_DR;
                    end else if (cnt_inc_s >= CW'(POLL_MAX)) begin
                        fin_s = 1'b1;  fin_err_s = 1'b1;
                    end else begin
                        nxt_state = ST_POLL;
                    end
`endif
                end else begin
                    nxt_state = ST_POLL;
                end
            end
            ST_WAIT_IRQ: begin
`ifdef SPI_IRQ_WAIT_EN
                if (spi_interrupt_request_i) begin
                    nxt_state = ST_POLL;
                    nxt_phase = PH_SETUP;
                end else begin
                    nxt_phase = PH_GAP;
                    nxt_cnt = cnt_inc_s;
                    if (cnt_inc_s >= CW'(POLL_MAX)) begin
                        fin_s = 1'b1;  fin_err_s = 1'b1;
                    end else begin
                        nxt_state = ST_WAIT_IRQ;
                    end
                end
`else
                nxt_state = ST_IDLE;
                nxt_phase = PH_GAP;
`endif
            end
            ST_RD_DR: begin
                if (acc_done_s) begin
                    fin_s = 1'b1;
                    fin_err_s = PSLVERR_i;
                    fin_rx_s = PSLVERR_i ? 8'h00 : PRDATA_i;
                end else begin
                    nxt_state = ST_RD_DR;
                end
            end
            ST_DONE: begin
                nxt_state = ST_IDLE;
                nxt_phase = PH_GAP;
                nxt_gnt = '0;
            end
            default: begin
                nxt_state = ST_INIT_CR1;
                nxt_phase = PH_GAP;
            end
        endcase
        // Completion: pulse done to the owner (grant stays up through the pulse) and rotate the pointer.
        if (fin_s) begin
            nxt_state = ST_DONE;
            nxt_phase = PH_GAP;
            nxt_done = gnt_r;
            nxt_err = fin_err_s;
            nxt_rx = fin_rx_s;
            nxt_ptr = (owner_r == PW'(NREQ - 1)) ? {PW{1'b0}} : owner_r + PW'(1);
        end else begin
            nxt_done = '0;
        end
        case (nxt_state)
            ST_INIT_CR1: begin is_acc_s = 1'b1; nxt_paddr = 3'd0; nxt_pwrite = 1'b1; nxt_pwdata = CR1_INIT; end
            ST_INIT_CR2: begin is_acc_s = 1'b1; nxt_paddr = 3'd1; nxt_pwrite = 1'b1; nxt_pwdata = CR2_INIT; end
            ST_INIT_BR:  begin is_acc_s = 1'b1; nxt_paddr = 3'd2; nxt_pwrite = 1'b1; nxt_pwdata = BR_INIT;  end
            ST_WR_DR:    begin is_acc_s = 1'b1; nxt_paddr = 3'd5; nxt_pwrite = 1'b1; nxt_pwdata = nxt_tx;   end
            ST_POLL:     begin is_acc_s = 1'b1; nxt_paddr = 3'd3; nxt_pwrite = 1'b0; nxt_pwdata = 8'h00;    end
            ST_RD_DR:    begin is_acc_s = 1'b1; nxt_paddr = 3'd5; nxt_pwrite = 1'b0; nxt_pwdata = 8'h00;    end
            default:     begin is_acc_s = 1'b0; nxt_paddr = 3'd0; nxt_pwrite = 1'b0; nxt_pwdata = 8'h00;    end
        endcase
        nxt_psel = is_acc_s && ((nxt_phase == PH_SETUP) || (nxt_phase == PH_ACCESS));
        nxt_penable = is_acc_s && (nxt_phase == PH_ACCESS);
        if (!nxt_psel) begin
            nxt_paddr = 3'd0;  nxt_pwrite = 1'b0;  nxt_pwdata = 8'h00;
        end else begin
            nxt_paddr = nxt_paddr;
        end
    end

    // State and output registers.
    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            state_r <= ST_INIT_CR1;  phase_r <= PH_GAP;  gnt_r <= '0;  done_r <= '0;
            owner_r <= '0;  ptr_r <= '0;  tx_r <= 8'h00;  rx_r <= 8'h00;  cnt_r <= '0;
            err_r <= 1'b0;  init_done_r <= 1'b0;  psel_r <= 1'b0;  penable_r <= 1'b0;
            pwrite_r <= 1'b0;  paddr_r <= 3'd0;  pwdata_r <= 8'h00;
        end else begin
            state_r <= nxt_state;  phase_r <= nxt_phase;  gnt_r <= nxt_gnt;  done_r <= nxt_done;
            owner_r <= nxt_owner;  ptr_r <= nxt_ptr;  tx_r <= nxt_tx;  rx_r <= nxt_rx;  cnt_r <= nxt_cnt;
            err_r <= nxt_err;  init_done_r <= nxt_init_done;  psel_r <= nxt_psel;  penable_r <= nxt_penable;
            pwrite_r <= nxt_pwrite;  paddr_r <= nxt_paddr;  pwdata_r <= nxt_pwdata;
        end
    end

    assign gnt_o = gnt_r;          assign done_o = done_r;        assign err_o = err_r;
    assign rx_data_o = rx_r;       assign init_done_o = init_done_r;
    assign PSEL_o = psel_r;        assign PENABLE_o = penable_r;  assign PWRITE_o = pwrite_r;
    assign PADDR_o = paddr_r;      assign PWDATA_o = pwdata_r;
endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Directed bench for spi_xfer_arbiter: behavioural APB slave with an access log and scripted SR/DR responses.
module tb_spi_xfer_arbiter;
    logic        PCLK = 1'b0;
    logic        PRESET_n;
    logic [1:0]  req_i;
    logic [15:0] req_data_i;
    logic [1:0]  gnt_o, done_o;
    logic        err_o, init_done_o, PSEL_o, PENABLE_o, PWRITE_o;
    logic [7:0]  rx_data_o, PWDATA_o, PRDATA_i;
    logic [2:0]  PADDR_o;
    logic        PREADY_i, PSLVERR_i, spi_interrupt_request_i;

    spi_xfer_arbiter #(.NREQ(2), .POLL_MAX(4)) dut (
        .PCLK(PCLK), .PRESET_n(PRESET_n), .req_i(req_i), .req_data_i(req_data_i),
        .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o), .rx_data_o(rx_data_o),
        .init_done_o(init_done_o), .PSEL_o(PSEL_o), .PENABLE_o(PENABLE_o),
        .PWRITE_o(PWRITE_o), .PADDR_o(PADDR_o), .PWDATA_o(PWDATA_o), .PRDATA_i(PRDATA_i),
        .PREADY_i(PREADY_i), .PSLVERR_i(PSLVERR_i),
        .spi_interrupt_request_i(spi_interrupt_request_i)
    );

    always #5 PCLK = ~PCLK;

    int checks = 0, failures = 0;
    int wait_states = 0, wait_cnt = 0, waits_seen = 0, sr_reads = 0, stab_viol = 0, gnt_overlap = 0;
    logic [7:0] sr_q[$];
    logic [7:0] sr_default = 8'h80, dr_val = 8'h00;
    logic       err_arm = 1'b0;
    logic [2:0] log_addr[$];
    logic       log_wr[$];
    logic [7:0] log_data[$];
    logic [2:0] s_addr;
    logic       s_wr;
    logic [7:0] s_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_log(input string tag, input int i, input logic [2:0] a, input logic w, input logic [7:0] d);
        chk($sformatf("%s_addr%0d", tag, i), log_addr[i], a);
        chk($sformatf("%s_wr%0d", tag, i), log_wr[i], w);
        chk($sformatf("%s_data%0d", tag, i), log_data[i], d);
    endtask

    task automatic clear_log();
        log_addr.delete(); log_wr.delete(); log_data.delete();
    endtask

    // APB slave: drives PREADY/PRDATA/PSLVERR on the falling edge, logs each completed access.
    initial begin
        PREADY_i = 1'b0; PRDATA_i = 8'h00; PSLVERR_i = 1'b0;
        forever begin
            @(negedge PCLK);
            PREADY_i = 1'b0; PSLVERR_i = 1'b0; PRDATA_i = 8'h00;
            if (PSEL_o && !PENABLE_o) begin
                s_addr = PADDR_o; s_wr = PWRITE_o; s_wdata = PWDATA_o; wait_cnt = 0;
            end else if (PSEL_o && PENABLE_o) begin
                if (PADDR_o !== s_addr || PWRITE_o !== s_wr || PWDATA_o !== s_wdata) stab_viol++;
                if (wait_cnt < wait_states) begin
                    wait_cnt++; waits_seen++;
                end else begin
                    PREADY_i = 1'b1;
                    if (!PWRITE_o && PADDR_o == 3'd3) begin
                        sr_reads++;
                        if (sr_q.size() > 0) PRDATA_i = sr_q.pop_front();
                        else PRDATA_i = sr_default;
                    end else if (!PWRITE_o && PADDR_o == 3'd5) begin
                        PRDATA_i = dr_val;
                    end
                    if (err_arm && PADDR_o == 3'd5 && PWRITE_o) begin
                        PSLVERR_i = 1'b1; err_arm = 1'b0;
                    end
                    log_addr.push_back(PADDR_o); log_wr.push_back(PWRITE_o);
                    log_data.push_back(PWRITE_o ? PWDATA_o : PRDATA_i);
                end
            end
        end
    end

    task automatic wait_done(output int cyc, output logic [1:0] dm, output logic [1:0] gm,
                             output logic e, output logic [7:0] rx);
        cyc = 0; dm = 2'b00; gm = 2'b00; e = 1'b0; rx = 8'h00;
        while (cyc < 200) begin
            @(posedge PCLK); cyc++;
            @(negedge PCLK);
            if (gnt_o == 2'b11) gnt_overlap++;
            if (done_o != 2'b00) begin
                dm = done_o; gm = gnt_o; e = err_o; rx = rx_data_o;
                break;
            end
        end
        chk("done_within_budget", (dm != 2'b00), 1'b1);
    endtask

    task automatic wait_init(input string tag);
        logic seen; int n;
        seen = 1'b0; n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge PCLK);
            if (init_done_o) begin seen = 1'b1; n = log_addr.size(); break; end
        end
        chk({tag, "_init_done"}, seen, 1'b1);
        chk({tag, "_init_nacc"}, n, 3);
        chk_log(tag, 0, 3'd0, 1'b1, 8'h52);
        chk_log(tag, 1, 3'd1, 1'b1, 8'h00);
        chk_log(tag, 2, 3'd2, 1'b1, 8'h11);
    endtask

    int cyc; logic [1:0] dm, gm; logic e; logic [7:0] rx; logic found;

    initial begin
        PRESET_n = 1'b0; req_i = 2'b00; req_data_i = 16'h0000; spi_interrupt_request_i = 1'b0;
        repeat (3) @(negedge PCLK);
        chk("rst_psel", PSEL_o, 1'b0);      chk("rst_penable", PENABLE_o, 1'b0);
        chk("rst_gnt", gnt_o, 2'b00);       chk("rst_done", done_o, 2'b00);
        chk("rst_init_done", init_done_o, 1'b0); chk("rst_rx", rx_data_o, 8'h00);
        clear_log();
        PRESET_n = 1'b1;
        wait_init("init");

        // Two persistent requesters alternate 0,1,0,1 starting from pointer 0.
        req_data_i = {8'h22, 8'h11}; req_i = 2'b11; sr_default = 8'h80;
        for (int t = 0; t < 4; t++) begin
            clear_log();
            wait_done(cyc, dm, gm, e, rx);
            chk($sformatf("rr_order%0d", t), dm, (t % 2 == 0) ? 2'b01 : 2'b10);
            chk($sformatf("rr_gnt%0d", t), gm, (t % 2 == 0) ? 2'b01 : 2'b10);
            chk($sformatf("rr_txbyte%0d", t), log_data[0], (t % 2 == 0) ? 8'h11 : 8'h22);
            chk($sformatf("rr_err%0d", t), e, 1'b0);
        end
        req_i = 2'b00;
        chk("gnt_no_overlap", gnt_overlap, 0);
        repeat (3) @(negedge PCLK);

        // Basic transfer with latency measurement.
        clear_log(); sr_q = '{8'h80}; dr_val = 8'h3C; req_data_i = {8'h00, 8'hA5}; req_i = 2'b01;
        wait_done(cyc, dm, gm, e, rx);
        req_i = 2'b00;
        chk("basic_done", dm, 2'b01); chk("basic_rx", rx, 8'h3C); chk("basic_err", e, 1'b0);
        chk("basic_latency", cyc + 1, 10);
        chk("basic_nacc", log_addr.size(), 3);
        chk_log("basic", 0, 3'd5, 1'b1, 8'hA5);
        chk_log("basic", 1, 3'd3, 1'b0, 8'h80);
        chk_log("basic", 2, 3'd5, 1'b0, 8'h3C);
        repeat (2) @(negedge PCLK);

        // Wait states on every access; SPIF found on the fourth SR read.
        wait_states = 2; waits_seen = 0; stab_viol = 0; sr_reads = 0;
        sr_q = '{8'h00, 8'h00, 8'h00, 8'h80}; dr_val = 8'hC3; req_data_i = {8'h00, 8'h5E}; req_i = 2'b01;
        wait_done(cyc, dm, gm, e, rx);
        req_i = 2'b00;
        chk("ws_sr_reads", sr_reads, 4); chk("ws_rx", rx, 8'hC3); chk("ws_err", e, 1'b0);
        chk("ws_stable", stab_viol, 0);  chk("ws_waits", waits_seen, 12);
        wait_states = 0;
        repeat (2) @(negedge PCLK);

        // Slave error on the DR write aborts before any SR read.
        clear_log(); sr_reads = 0; err_arm = 1'b1; req_data_i = {8'h00, 8'h77}; req_i = 2'b01;
        wait_done(cyc, dm, gm, e, rx);
        req_i = 2'b00;
        chk("slverr_done", dm, 2'b01); chk("slverr_err", e, 1'b1);
        chk("slverr_nacc", log_addr.size(), 1); chk("slverr_sr_reads", sr_reads, 0);
        repeat (2) @(negedge PCLK);
        sr_q = '{8'h80}; dr_val = 8'h5A; req_i = 2'b01;
        wait_done(cyc, dm, gm, e, rx);
        req_i = 2'b00;
        chk("after_err_done", dm, 2'b01); chk("after_err_rx", rx, 8'h5A); chk("after_err_err", e, 1'b0);
        repeat (2) @(negedge PCLK);

        // SR stuck clear: timeout after POLL_MAX=4 reads.
        sr_default = 8'h00; sr_reads = 0; req_i = 2'b01;
        wait_done(cyc, dm, gm, e, rx);
        req_i = 2'b00;
        chk("tmo_done", dm, 2'b01); chk("tmo_err", e, 1'b1);
        chk("tmo_rx", rx, 8'h00);   chk("tmo_sr_reads", sr_reads, 4);
        repeat (2) @(negedge PCLK);

        // Reset in the middle of polling: APB drops at once and init repeats.
        req_i = 2'b01; found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge PCLK);
            if (PSEL_o && PADDR_o == 3'd3) found = 1'b1;
        end
        chk("mid_reach_poll", found, 1'b1);
        PRESET_n = 1'b0; #1;
        chk("mid_psel", PSEL_o, 1'b0); chk("mid_penable", PENABLE_o, 1'b0);
        chk("mid_gnt", gnt_o, 2'b00);  chk("mid_done", done_o, 2'b00);
        chk("mid_init_done", init_done_o, 1'b0);
        req_i = 2'b00;
        repeat (2) @(negedge PCLK);
        clear_log();
        PRESET_n = 1'b1;
        wait_init("reinit");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
